// File: rtl/mic_array_scheduler.sv
// Round-robin scheduler sharing one output channel between NUM_ADC I2S receivers.
// States: IDLE | no word on the output, arbitrate pending receivers;  SEND | word presented, wait for out_ready.
module mic_array_scheduler #(
  parameter int NUM_ADC = 4,
  parameter int WORD_W  = 64,
  parameter int SRC_W   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [NUM_ADC-1:0]        adc_valid,
  input  logic [NUM_ADC*WORD_W-1:0] adc_data,
  input  logic                      out_ready,
  input  logic                      ovf_clr,
  output logic                      out_valid,
  output logic [WORD_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      frame_done,
  output logic [NUM_ADC-1:0]        overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [NUM_ADC-1:0]  adc_valid_d, pend, sent_mask, rise;
  logic [NUM_ADC-1:0]  grant_oh, taken, src_oh, ovf_set;
  logic [WORD_W-1:0]   hold [NUM_ADC];
  logic [WORD_W-1:0]   grant_word;
  logic [SRC_W-1:0]    rr_ptr, grant_src;
  logic                grant, handshake;
  int                  scan_idx;

  assign rise      = adc_valid & ~adc_valid_d;
  assign out_valid = (state == SEND);
  assign taken     = grant ? grant_oh : '0;
  assign ovf_set   = rise & pend & ~taken;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: if (EN && (|pend)) begin
        grant     = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (out_ready) begin
        handshake = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan backwards from the farthest slot so the last hit is the first pending one after rr_ptr.
  always_comb begin
    grant_src  = '0;
    grant_word = '0;
    grant_oh   = '0;
    scan_idx   = 0;
    for (int k = NUM_ADC - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_ADC) scan_idx = scan_idx - NUM_ADC;
      if (pend[scan_idx]) begin
        grant_src          = scan_idx[SRC_W-1:0];
        grant_word         = hold[scan_idx];
        grant_oh           = '0;
        grant_oh[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    src_oh = '0;
    for (int i = 0; i < NUM_ADC; i++) src_oh[i] = (out_src == SRC_W'(i));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      adc_valid_d <= '1;
      pend        <= '0;
      sent_mask   <= '0;
      overflow    <= '0;
      rr_ptr      <= '0;
      out_data    <= '0;
      out_src     <= '0;
      frame_done  <= 1'b0;
      for (int i = 0; i < NUM_ADC; i++) hold[i] <= '0;
    end else begin
      adc_valid_d <= adc_valid;
      frame_done  <= 1'b0;
      overflow    <= (ovf_clr ? '0 : overflow) | ovf_set;
      if (grant) begin
        out_data <= grant_word;
        out_src  <= grant_src;
        rr_ptr   <= (grant_src == SRC_W'(NUM_ADC - 1)) ? '0 : grant_src + 1'b1;
      end
      if (handshake) begin
        if ((sent_mask | src_oh) == '1) begin
          frame_done <= 1'b1;
          sent_mask  <= '0;
        end else begin
          sent_mask <= sent_mask | src_oh;
        end
      end
      // A capture on the granted receiver re-arms pend with the new word; the old one is already out.
      for (int i = 0; i < NUM_ADC; i++) begin
        if (rise[i]) begin
          hold[i] <= adc_data[i*WORD_W +: WORD_W];
          pend[i] <= 1'b1;
        end else if (taken[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_array_scheduler.sv
// Bench for mic_array_scheduler: vector table, directed corner sequences, random run against a reference model.
module tb_mic_array_scheduler;
  localparam int N = 4;
  localparam int W = 64;
  localparam int S = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic           RST, EN, out_ready, ovf_clr;
  logic [N-1:0]   adc_valid;
  logic [N*W-1:0] adc_data;
  logic           out_valid, frame_done;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_src;
  logic [N-1:0]   overflow;

  int checks = 0;
  int errors = 0;

  mic_array_scheduler #(.NUM_ADC(N), .WORD_W(W), .SRC_W(S)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .adc_valid(adc_valid), .adc_data(adc_data),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .frame_done(frame_done), .overflow(overflow)
  );

  // Reference model state
  bit           m_busy, m_frame;
  logic [W-1:0] m_data;
  int           m_src, m_ptr;
  bit [N-1:0]   m_pend, m_ovf, m_sent, m_prev;
  logic [W-1:0] m_hold [N];

  typedef struct {
    bit           rst;
    bit [N-1:0]   valid;
    logic [W-1:0] word;
    bit           rdy;
    logic         exp_v;
    logic [W-1:0] exp_d;
    logic [S-1:0] exp_s;
    logic         exp_f;
    logic [N-1:0] exp_o;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (RST) begin
      m_busy = 0; m_frame = 0; m_data = '0; m_src = 0; m_ptr = 0;
      m_pend = '0; m_ovf = '0; m_sent = '0; m_prev = '1;
      for (int i = 0; i < N; i++) m_hold[i] = '0;
    end else begin
      m_frame = 0;
      if (!m_busy && EN)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (m_pend[j] && g < 0) g = j;
        end
      if (ovf_clr) m_ovf = '0;
      if (m_busy && out_ready) begin
        m_busy = 0;
        m_sent[m_src] = 1'b1;
        if (m_sent == '1) begin
          m_frame = 1;
          m_sent  = '0;
        end
      end
      if (g >= 0) begin
        m_data  = m_hold[g];
        m_src   = g;
        m_busy  = 1;
        m_pend[g] = 1'b0;
        m_ptr   = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (adc_valid[i] && !m_prev[i]) begin
          if (m_pend[i] && i != g) m_ovf[i] = 1'b1;
          m_hold[i] = adc_data[i*W +: W];
          m_pend[i] = 1'b1;
        end
      m_prev = adc_valid;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit [N-1:0] v, input logic [N*W-1:0] d,
                     input bit rdy, input bit c);
    RST = r; EN = e; adc_valid = v; adc_data = d; out_ready = rdy; ovf_clr = c;
    @(posedge CLK);
    model_step();
    #1;
    checks++;
    if ({out_valid, out_data, out_src, frame_done, overflow} !==
        {m_busy, m_data, S'(m_src), m_frame, m_ovf}) begin
      errors++;
      $display("FAIL model: got v=%0b d=%h s=%0d f=%0b o=%b expected v=%0b d=%h s=%0d f=%0b o=%b",
               out_valid, out_data, out_src, frame_done, overflow,
               m_busy, m_data, m_src, m_frame, m_ovf);
    end
  endtask

  initial begin
    logic [W-1:0]   w1;
    logic [N*W-1:0] d;
    bit [N-1:0]     v, flip;
    bit             r, e, rdy, c;

    RST = 1; EN = 0; adc_valid = '0; adc_data = '0; out_ready = 0; ovf_clr = 0;
    w1 = 64'h0100_00AB_CD00_1234;

    // Single capture on receiver 2, then reset with adc_valid held high.
    tbl[0] = '{1, 4'b0000, w1, 1, 0, 64'h0, 4'd0, 0, 4'b0000};
    tbl[1] = '{0, 4'b0000, w1, 1, 0, 64'h0, 4'd0, 0, 4'b0000};
    tbl[2] = '{0, 4'b0100, w1, 1, 0, 64'h0, 4'd0, 0, 4'b0000};
    tbl[3] = '{0, 4'b0100, w1, 1, 1, w1,    4'd2, 0, 4'b0000};
    tbl[4] = '{0, 4'b0100, w1, 1, 0, w1,    4'd2, 0, 4'b0000};
    tbl[5] = '{0, 4'b0000, w1, 1, 0, w1,    4'd2, 0, 4'b0000};
    tbl[6] = '{1, 4'b1111, w1, 1, 0, 64'h0, 4'd0, 0, 4'b0000};
    tbl[7] = '{0, 4'b1111, w1, 1, 0, 64'h0, 4'd0, 0, 4'b0000};
    tbl[8] = '{0, 4'b1111, w1, 1, 0, 64'h0, 4'd0, 0, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].rst, 1, tbl[i].valid, mk(tbl[i].word, tbl[i].word, tbl[i].word, tbl[i].word), tbl[i].rdy, 0);
      chk("tbl_valid", out_valid, tbl[i].exp_v);
      chk("tbl_data", out_data, tbl[i].exp_d);
      chk("tbl_src", out_src, tbl[i].exp_s);
      chk("tbl_frame", frame_done, tbl[i].exp_f);
      chk("tbl_ovf", overflow, tbl[i].exp_o);
    end

    // Round-robin over four simultaneous rises, frame pulse after src 3.
    cyc(1, 1, 0, 0, 1, 0); cyc(0, 1, 0, 0, 1, 0);
    d = mk(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 4'hF, d, 1, 0);
      chk("rr_valid", out_valid, ((k % 2 == 1) && k <= 7) ? 1'b1 : 1'b0);
      chk("rr_frame", frame_done, (k == 8) ? 1'b1 : 1'b0);
      if ((k % 2 == 1) && k <= 7) begin
        chk("rr_src", out_src, 64'((k - 1) / 2));
        chk("rr_data", out_data, 64'(8'hA0 + (k - 1) / 2));
      end
    end

    // Backpressure: stall 10 cycles, a rise elsewhere only sets pend.
    cyc(1, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    d = mk(64'h55, 64'h0, 64'h0, 64'h33);
    cyc(0, 1, 4'b0001, d, 0, 0);
    cyc(0, 1, 4'b0001, d, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, (k >= 3) ? 4'b1001 : 4'b0001, d, 0, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 64'h55);
      chk("bp_ovf", overflow, 0);
    end
    cyc(0, 1, 4'b1001, d, 1, 0);
    chk("bp_release", out_valid, 0);
    cyc(0, 1, 4'b1001, d, 1, 0);
    chk("bp_next_src", out_src, 3);
    chk("bp_next_data", out_data, 64'h33);
    cyc(0, 1, 4'b1001, d, 1, 0);

    // Overrun on receiver 1 while src 0 is stalled.
    cyc(1, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 4'b0001, mk(64'h10, 64'h11, 0, 0), 0, 0);
    cyc(0, 1, 4'b0001, mk(64'h10, 64'h11, 0, 0), 0, 0);
    cyc(0, 1, 4'b0011, mk(64'h10, 64'h11, 0, 0), 0, 0);
    chk("ovr_first", overflow, 4'b0000);
    cyc(0, 1, 4'b0001, mk(64'h10, 64'h11, 0, 0), 0, 0);
    cyc(0, 1, 4'b0011, mk(64'h10, 64'h22, 0, 0), 0, 0);
    chk("ovr_set", overflow, 4'b0010);
    cyc(0, 1, 4'b0011, mk(64'h10, 64'h22, 0, 0), 1, 0);
    cyc(0, 1, 4'b0011, mk(64'h10, 64'h22, 0, 0), 1, 0);
    chk("ovr_src", out_src, 1);
    chk("ovr_data", out_data, 64'h22);
    cyc(0, 1, 4'b0011, mk(64'h10, 64'h22, 0, 0), 1, 1);
    chk("ovr_clr", overflow, 4'b0000);

    // Fairness after wrap: rr_ptr=3 with pend=1001.
    d = mk(64'hC0, 64'hC1, 64'hC2, 64'hC3);
    cyc(1, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 4'b0100, d, 0, 0);
    cyc(0, 1, 4'b0100, d, 0, 0);
    chk("fair_pre", out_src, 2);
    cyc(0, 1, 4'b0100, d, 1, 0);
    cyc(0, 1, 4'b1101, d, 1, 0);
    cyc(0, 1, 4'b1101, d, 0, 0);
    chk("fair_first", out_src, 3);
    chk("fair_first_data", out_data, 64'hC3);
    cyc(0, 1, 4'b1101, d, 1, 0);
    cyc(0, 1, 4'b1101, d, 1, 0);
    chk("fair_second", out_src, 0);
    chk("fair_second_v", out_valid, 1);

    // EN gating, then reset mid-SEND with adc_valid held high.
    d = mk(0, 64'hE1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 4'b0010, d, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 4'b0010, d, 0, 0);
      chk("en_hold", out_valid, 0);
    end
    cyc(0, 1, 4'b0010, d, 0, 0);
    chk("en_grant", out_valid, 1);
    chk("en_src", out_src, 1);
    chk("en_data", out_data, 64'hE1);
    cyc(0, 0, 4'b0010, d, 0, 0);
    chk("en_no_abort", out_valid, 1);
    cyc(1, 1, 4'b1111, d, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_ovf", overflow, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 4'b1111, d, 1, 0);
      chk("rst_no_capture", out_valid, 0);
    end

    // Randomised traffic against the model.
    v = '0;
    for (int k = 0; k < 3000; k++) begin
      flip = N'($urandom & $urandom);
      v    = v ^ flip;
      r    = ($urandom_range(0, 99) == 0);
      e    = ($urandom_range(0, 7) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      c    = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N * W / 32; i++) d[i*32 +: 32] = $urandom;
      cyc(r, e, v, d, rdy, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
